// File: rtl/read_master_sched_pkg.sv
// Shared types and helpers for the read master scheduler: FSM state encoding
// and the byte-to-word shift derived from the read master's word size.
package read_master_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } rms_state_e;

  // log2 of a power-of-two word size; evaluated at elaboration only.
  function automatic int addr_shift(input int inc);
    int s;
    s = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) == inc) s = i;
    end
    return s;
  endfunction

endpackage

// File: rtl/read_master_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr_i, ptr_i+1, ... (wrapping)
// and returns the first requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin : p_search
    int               s;
    logic [IDX_W-1:0] c;
    // NOTE: every output gets a default before the search so no path leaves
    // a value held over from a previous evaluation, which would infer a latch.
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    s       = 0;
    c       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(ptr_i) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      c = IDX_W'(s);
      if (!valid_o && req_i[c]) begin
        valid_o    = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = c;
      end
    end
  end

endmodule

// File: rtl/read_master_scheduler.sv
// Round-robin scheduler sharing one burst read master between NUM_REQ requesters.
// Optional rejection of lengths that are not whole bursts: RMS_LENGTH_CHECK_EN.
module read_master_scheduler
  import read_master_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDRESS_INC = 4,
  parameter int BURST_BYTES = 256
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic [NUM_REQ-1:0]   iReq,
  input  logic [NUM_REQ*32-1:0] iReq_address,
  input  logic [NUM_REQ*32-1:0] iReq_length,
  output logic [NUM_REQ-1:0]   oGrant,
  output logic [NUM_REQ-1:0]   oDone,
  output logic                 oError,
  output logic                 oBusy,
  output logic                 oStart,
  output logic [31:0]          oStart_read_address,
  output logic [31:0]          oLength,
  input  logic                 iRM_pop
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SHIFT = addr_shift(ADDRESS_INC);

  rms_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               error_q, error_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        len_q, len_d;
  logic [29:0]        cnt_q, cnt_d;
  logic [29:0]        tgt_q, tgt_d;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic [31:0]        win_addr;
  logic [31:0]        win_len;
  logic [29:0]        win_tgt;
  logic               len_bad;
  logic               finish;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (iReq),
    .ptr_i   (ptr_q),
    .grant_o (win_onehot),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        win_addr = iReq_address[32*i +: 32];
        win_len  = iReq_length[32*i +: 32];
      end
    end
  end

  assign win_tgt = 30'(win_len >> SHIFT);

`ifdef RMS_LENGTH_CHECK_EN
  assign len_bad = (win_len == 32'd0) || ((win_len % 32'(BURST_BYTES)) != 32'd0);
`else
  assign len_bad = 1'b0;
`endif

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // A zero target completes straight from START; otherwise the pop that
  // brings the count to the target ends the transfer (START pops included).
  assign finish = ((state_q == S_START) && (tgt_q == '0)) ||
                  (iRM_pop && (cnt_q == tgt_q - 30'd1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    done_d  = '0;
    error_d = 1'b0;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          addr_d = win_addr;
          len_d  = win_len;
          tgt_d  = win_tgt;
          cnt_d  = '0;
          idx_d  = win_idx;
          if (len_bad) begin
            done_d  = win_onehot;
            error_d = 1'b1;
            ptr_d   = wrap_inc(win_idx);
            state_d = S_DONE;
          end else begin
            grant_d = win_onehot;
            state_d = S_START;
          end
        end
      end
      S_START, S_RUN: begin
        if (iRM_pop) cnt_d = cnt_q + 30'd1;
        if (finish) begin
          done_d  = grant_q;
          grant_d = '0;
          ptr_d   = wrap_inc(idx_q);
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      error_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign oGrant              = grant_q;
  assign oDone               = done_q;
  assign oError              = error_q;
  assign oBusy               = (state_q != S_IDLE);
  assign oStart              = (state_q == S_START);
  assign oStart_read_address = addr_q;
  assign oLength             = len_q;

endmodule

// File: tb/tb_read_master_scheduler.sv
// Self-checking bench for read_master_scheduler: directed vector table, reset
// abort, round-robin and length corner cases, then randomized transactions.
module tb_read_master_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int ADDRESS_INC = 4;
  localparam int BURST_BYTES = 256;
`ifdef RMS_LENGTH_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic                  iClk;
  logic                  iReset;
  logic [NUM_REQ-1:0]    iReq;
  logic [NUM_REQ*32-1:0] iReq_address;
  logic [NUM_REQ*32-1:0] iReq_length;
  logic [NUM_REQ-1:0]    oGrant;
  logic [NUM_REQ-1:0]    oDone;
  logic                  oError;
  logic                  oBusy;
  logic                  oStart;
  logic [31:0]           oStart_read_address;
  logic [31:0]           oLength;
  logic                  iRM_pop;

  int errors = 0;
  int checks = 0;

  read_master_scheduler #(
    .NUM_REQ(NUM_REQ), .ADDRESS_INC(ADDRESS_INC), .BURST_BYTES(BURST_BYTES)
  ) dut (
    .iClk                (iClk),
    .iReset              (iReset),
    .iReq                (iReq),
    .iReq_address        (iReq_address),
    .iReq_length         (iReq_length),
    .oGrant              (oGrant),
    .oDone               (oDone),
    .oError              (oError),
    .oBusy               (oBusy),
    .oStart              (oStart),
    .oStart_read_address (oStart_read_address),
    .oLength             (oLength),
    .iRM_pop             (iRM_pop)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_bad_len(input logic [31:0] len);
    return LEN_CHK && ((len == 0) || (len % BURST_BYTES != 0));
  endfunction

  // One transaction from the requester side. Called on a falling edge with the
  // DUT idle; returns on the falling edge of the IDLE cycle after completion.
  task automatic run_txn(input logic [3:0] mask, input logic [3:0] exp_grant,
                         input logic [31:0] exp_addr, input logic [31:0] exp_len,
                         input int exp_target, input bit exp_reject, input int gap_max,
                         input bit pop_in_start, input bit keep_req);
    bit seen, early, first, pop;
    int pops, gap_cnt, starts;
    seen = 0;
    iReq = mask;
    for (int w = 0; w < 8; w++) begin
      @(negedge iClk);
      iRM_pop = 1'b0;
      if (oStart || oDone != '0) begin
        seen = 1;
        break;
      end
    end
    check("event_seen", 64'(seen), 64'(1));
    if (!seen) return;
    check("start_vs_reject", 64'(oStart), 64'(!exp_reject));
    check("error_flag", 64'(oError), 64'(exp_reject));
    if (exp_reject) begin
      check("reject_done", 64'(oDone), 64'(exp_grant));
      check("reject_grant", 64'(oGrant), 64'(0));
    end else begin
      check("grant", 64'(oGrant), 64'(exp_grant));
      check("start_addr", 64'(oStart_read_address), 64'(exp_addr));
      check("length", 64'(oLength), 64'(exp_len));
      check("busy_start", 64'(oBusy), 64'(1));
      check("done_at_start", 64'(oDone), 64'(0));
      pops = 0; gap_cnt = 0; starts = 0; early = 0; first = 1;
      if (exp_target == 0) @(negedge iClk);
      while (pops < exp_target) begin
        pop = first ? pop_in_start : ((gap_cnt >= gap_max) || ($urandom_range(0, 1) == 1));
        first = 0;
        iRM_pop = pop;
        if (pop) begin
          pops++;
          gap_cnt = 0;
        end else begin
          gap_cnt++;
        end
        @(negedge iClk);
        iRM_pop = 1'b0;
        if (pops < exp_target) begin
          if (oDone != '0) early = 1;
          if (oStart) starts++;
        end
      end
      check("no_early_done", 64'(early), 64'(0));
      check("single_start", 64'(starts), 64'(0));
      check("done", 64'(oDone), 64'(exp_grant));
      check("grant_cleared", 64'(oGrant), 64'(0));
      check("error_low", 64'(oError), 64'(0));
    end
    check("start_low_in_done", 64'(oStart), 64'(0));
    check("busy_in_done", 64'(oBusy), 64'(1));
    iRM_pop = 1'($urandom_range(0, 1));
    if (!keep_req) iReq = iReq & ~exp_grant;
    @(negedge iClk);
    check("idle_quiet", 64'({oBusy, oStart, oError, oDone, oGrant}), 64'(0));
    iRM_pop = 1'($urandom_range(0, 1));
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] base;
    logic [31:0] len;
    logic [3:0]  exp_grant;
    logic [31:0] exp_addr;
    int          exp_target;
  } vec_t;

  vec_t        tbl[7];
  int          ptr_m;
  logic [3:0]  pend;
  logic [31:0] m_addr[4];
  logic [31:0] m_len[4];

  initial begin
    // Slot i gets base + i*0x10000; ptr walks from 0 after reset.
    tbl[0] = '{4'b0001, 32'h0000_1000,  512, 4'b0001, 32'h0000_1000, 128};
    tbl[1] = '{4'b1111, 32'h0000_2000,  256, 4'b0010, 32'h0001_2000,  64};
    tbl[2] = '{4'b0001, 32'h0000_0000, 1024, 4'b0001, 32'h0000_0000, 256};
    tbl[3] = '{4'b1000, 32'hF000_0000,  256, 4'b1000, 32'hF003_0000,  64};
    tbl[4] = '{4'b0110, 32'h0000_0100,  768, 4'b0010, 32'h0001_0100, 192};
    tbl[5] = '{4'b0101, 32'h0000_0008,  256, 4'b0100, 32'h0002_0008,  64};
    tbl[6] = '{4'b0011, 32'h0000_0000,  256, 4'b0001, 32'h0000_0000,  64};

    iReset = 1'b1; iReq = '0; iReq_address = '0; iReq_length = '0; iRM_pop = 1'b0;
    repeat (3) @(negedge iClk);
    check("reset_flags", 64'({oGrant, oDone, oError, oBusy, oStart}), 64'(0));
    check("reset_addr", 64'(oStart_read_address), 64'(0));
    check("reset_len", 64'(oLength), 64'(0));
    iReset = 1'b0;
    @(negedge iClk);
    check("idle_after_reset", 64'(oBusy), 64'(0));

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        iReq_address[32*i +: 32] = tbl[v].base + 32'(i) * 32'h1_0000;
        iReq_length[32*i +: 32]  = tbl[v].len;
      end
      run_txn(tbl[v].mask, tbl[v].exp_grant, tbl[v].exp_addr, tbl[v].len,
              tbl[v].exp_target, 1'b0, 0, 1'b0, 1'b0);
    end

    // Reset in the middle of a 64-word transfer after 50 pops.
    iRM_pop = 1'b0;
    iReq_address[31:0] = 32'h0000_5000;
    iReq_length[31:0]  = 256;
    iReq = 4'b0001;
    begin
      bit seen_start;
      seen_start = 0;
      for (int w = 0; w < 8; w++) begin
        @(negedge iClk);
        if (oStart) begin
          seen_start = 1;
          break;
        end
      end
      check("abort_start_seen", 64'(seen_start), 64'(1));
    end
    for (int p = 0; p < 50; p++) begin
      iRM_pop = 1'b1;
      @(negedge iClk);
    end
    check("abort_still_busy", 64'({oBusy, oDone}), 64'({1'b1, 4'b0000}));
    iReset = 1'b1; iRM_pop = 1'b0; iReq = '0;
    @(negedge iClk);
    check("abort_flags", 64'({oGrant, oDone, oError, oBusy, oStart}), 64'(0));
    check("abort_addr_len", 64'({oStart_read_address, oLength}), 64'(0));
    iReset = 1'b0;
    @(negedge iClk);
    check("abort_no_done", 64'({oDone, oBusy}), 64'(0));

    // All four requesting continuously from ptr 0: order 0,1,2,3,0.
    for (int i = 0; i < NUM_REQ; i++) begin
      iReq_address[32*i +: 32] = 32'h0000_4000 + 32'(i) * 32'h100;
      iReq_length[32*i +: 32]  = 256;
    end
    run_txn(4'b1111, 4'b0001, 32'h4000, 256, 64, 1'b0, 0, 1'b1, 1'b1);
    run_txn(4'b1111, 4'b0010, 32'h4100, 256, 64, 1'b0, 2, 1'b0, 1'b1);
    run_txn(4'b1111, 4'b0100, 32'h4200, 256, 64, 1'b0, 1, 1'b1, 1'b1);
    run_txn(4'b1111, 4'b1000, 32'h4300, 256, 64, 1'b0, 3, 1'b0, 1'b1);
    run_txn(4'b1111, 4'b0001, 32'h4000, 256, 64, 1'b0, 0, 1'b0, 1'b0);
    iReq = '0;

    // Length 100 from requester 2 (ptr now 1), requester 3 waiting behind it.
    iReq_address[64 +: 32] = 32'h0000_7000;
    iReq_length[64 +: 32]  = 100;
    iReq_address[96 +: 32] = 32'h0000_8000;
    iReq_length[96 +: 32]  = 256;
    run_txn(4'b1100, 4'b0100, 32'h7000, 100, 25, LEN_CHK, 0, 1'b0, 1'b0);
    run_txn(4'b1000, 4'b1000, 32'h8000, 256, 64, 1'b0, 1, 1'b1, 1'b0);

    // Randomized traffic against a transaction-level round-robin model.
    ptr_m = 0;
    pend  = '0;
    for (int t = 0; t < 40; t++) begin
      int w;
      bit found;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1 || (i == NUM_REQ - 1 && pend == '0))) begin
          int r;
          pend[i]   = 1'b1;
          m_addr[i] = $urandom & 32'hFFFF_FFFC;
          r         = int'($urandom_range(0, 9));
          m_len[i]  = (r < 6) ? 32'(BURST_BYTES * int'($urandom_range(1, 2)))
                              : 32'($urandom_range(0, 120));
          iReq_address[32*i +: 32] = m_addr[i];
          iReq_length[32*i +: 32]  = m_len[i];
        end
      end
      w = 0;
      found = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (ptr_m + k) % NUM_REQ;
        if (!found && pend[c]) begin
          w = c;
          found = 1;
        end
      end
      run_txn(pend, 4'(1 << w), m_addr[w], m_len[w], int'(m_len[w] / ADDRESS_INC),
              is_bad_len(m_len[w]), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b0);
      pend[w] = 1'b0;
      ptr_m   = (w + 1) % NUM_REQ;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
